// File: rtl/instruction_memory.sv
// instruction_memory: word-indexed 32-bit instruction store with a zero-latency fetch.
// Ports: clk, reset (sync, active-high), PC -> instruction/oor.
// prog_we/prog_addr/prog_data form the write port, active only with IMEM_PROG_PORT_EN.
module instruction_memory #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        oor,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef logic [DEPTH-1:0][31:0] image_t;

  localparam image_t BOOT = {
    {((DEPTH - 3) * 32){1'b0}},
    32'h00000063,
    32'h00002083,
    32'h40000033
  };

  logic          pc_in;
  logic [AW-1:0] pc_idx;
  image_t        img;

  // Full 32-bit compare so high PC bits never alias into the array.
  assign pc_in  = PC < DEPTH_W;
  assign pc_idx = PC[AW-1:0];

  always_comb begin
    instruction = '0;
    oor         = 1'b1;
    if (pc_in) begin
      instruction = img[pc_idx];
      oor         = 1'b0;
    end
  end

`ifdef IMEM_PROG_PORT_EN

  logic          wr_in;
  logic [AW-1:0] wr_idx;
  image_t        mem_q = BOOT;
  image_t        mem_d;

  assign wr_in  = prog_addr < DEPTH_W;
  assign wr_idx = prog_addr[AW-1:0];

  // Reset wins over a same-edge write; out-of-range writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (reset) begin
      mem_d = BOOT;
    end else if (prog_we && wr_in) begin
      mem_d[wr_idx] = prog_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign img = mem_q;

`else

  // Without the write port the contents can only ever be the boot image.
  logic unused_prog;

  assign img         = BOOT;
  assign unused_prog = ^{clk, reset, prog_we, prog_addr, prog_data};

`endif

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: randomized self-checking bench for instruction_memory.
// Expectations come from a plain word-array model of the memory image.
module tb_instruction_memory;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        oor;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  int checks = 0;
  int errors = 0;

`ifdef IMEM_PROG_PORT_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic [31:0] model [256];

  instruction_memory #(.DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC         (PC),
    .instruction(instruction),
    .oor        (oor),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_boot();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    model[0] = 32'h40000033;
    model[1] = 32'h00002083;
    model[2] = 32'h00000063;
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] pc);
    if (pc < 32'd256) return model[pc[7:0]];
    return 32'h0;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d);
    if (PROG_EN && a < 32'd256) model[a[7:0]] = d;
  endfunction

  task automatic test_reset();
    PC = 32'd0;
    #1;
    checks++;
    if (instruction !== 32'h40000033) begin
      errors++;
      $display("FAIL pre_reset_word0 got %h exp %h", instruction, 32'h40000033);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_boot();
    PC = 32'd0;
    #1;
    checks++;
    if (instruction !== 32'h40000033 || oor !== 1'b0) begin
      errors++;
      $display("FAIL reset_word0 got %h/%b exp %h/0", instruction, oor, 32'h40000033);
    end
  endtask

  task automatic test_boot_image();
    logic [31:0] exp [3];
    exp[0] = 32'h40000033;
    exp[1] = 32'h00002083;
    exp[2] = 32'h00000063;
    for (int i = 0; i < 3; i++) begin
      PC = 32'(i);
      #1;
      checks++;
      if (instruction !== exp[i] || oor !== 1'b0) begin
        errors++;
        $display("FAIL boot_word%0d got %h/%b exp %h/0", i, instruction, oor, exp[i]);
      end
    end
  endtask

  task automatic test_zero_fill();
    for (int i = 3; i < 256; i++) begin
      PC = 32'(i);
      #1;
      checks++;
      if (instruction !== 32'h0 || oor !== 1'b0) begin
        errors++;
        $display("FAIL zero_fill pc=%0d got %h/%b exp 0/0", i, instruction, oor);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] pcs [4];
    pcs[0] = 32'd256;
    pcs[1] = 32'hFFFFFFFF;
    pcs[2] = 32'h00000101;
    pcs[3] = 32'h80000000;
    for (int i = 0; i < 4; i++) begin
      PC = pcs[i];
      #1;
      checks++;
      if (instruction !== 32'h0 || oor !== 1'b1) begin
        errors++;
        $display("FAIL oor pc=%h got %h/%b exp 0/1", pcs[i], instruction, oor);
      end
    end
  endtask

  task automatic test_program();
    logic [31:0] exp5;
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 32'd5;
    prog_data = 32'hDEADBEEF;
    PC        = 32'd5;
    #1;
    checks++;
    if (instruction !== 32'h0) begin
      errors++;
      $display("FAIL prog_before_edge got %h exp %h", instruction, 32'h0);
    end
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    model_write(32'd5, 32'hDEADBEEF);
    exp5 = PROG_EN ? 32'hDEADBEEF : 32'h0;
    #1;
    checks++;
    if (instruction !== exp5) begin
      errors++;
      $display("FAIL prog_after_edge got %h exp %h", instruction, exp5);
    end
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 32'd300;
    prog_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    model_write(32'd300, 32'hCAFEF00D);
    for (int i = 0; i < 256; i++) begin
      PC = 32'(i);
      #1;
      checks++;
      if (instruction !== model[i]) begin
        errors++;
        $display("FAIL oor_write_sweep pc=%0d got %h exp %h", i, instruction, model[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 32'd0;
    prog_data = 32'h12345678;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    prog_we = 1'b0;
    model_boot();
    PC = 32'd0;
    #1;
    checks++;
    if (instruction !== 32'h40000033) begin
      errors++;
      $display("FAIL rst_prio_word0 got %h exp %h", instruction, 32'h40000033);
    end
    PC = 32'd5;
    #1;
    checks++;
    if (instruction !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio_word5 got %h exp %h", instruction, 32'h0);
    end
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      op = $urandom_range(0, 19);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(256, 400))
                                        : 32'($urandom_range(0, 15));
      d  = $urandom;
      reset     = (op == 0);
      prog_we   = (op >= 1 && op <= 8);
      prog_addr = a;
      prog_data = d;
      PC = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 15));
      #1;
      checks++;
      if (instruction !== exp_word(PC) || oor !== (PC >= 32'd256)) begin
        errors++;
        $display("FAIL rand_pre pc=%h got %h/%b exp %h/%b",
                 PC, instruction, oor, exp_word(PC), PC >= 32'd256);
      end
      @(posedge clk);
      if (reset) model_boot();
      else if (prog_we) model_write(a, d);
      #1;
      reset   = 1'b0;
      prog_we = 1'b0;
      PC = ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 15));
      #1;
      checks++;
      if (instruction !== exp_word(PC) || oor !== (PC >= 32'd256)) begin
        errors++;
        $display("FAIL rand_post pc=%h got %h/%b exp %h/%b",
                 PC, instruction, oor, exp_word(PC), PC >= 32'd256);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 32'h0;
    prog_data = 32'h0;
    PC        = 32'h0;
    model_boot();
    test_reset();
    test_boot_image();
    test_zero_fill();
    test_out_of_range();
    test_program();
    test_reset_priority();
    test_boot_image();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
